// File: rtl/data_regfile_sb.sv
// Parametrised data register file: two registered read ports, one write port,
// optional write-to-read bypass and zero register, plus a per-register pending scoreboard.
module data_regfile_sb #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned ADDR_W   = 3,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_we,
   input  logic [ADDR_W-1:0]        i_waddr,
   input  logic [DATA_W-1:0]        i_wdata,
   input  logic                     i_re,
   input  logic [ADDR_W-1:0]        i_raddr_a,
   input  logic [ADDR_W-1:0]        i_raddr_b,
   input  logic                     i_sb_set,
   input  logic [ADDR_W-1:0]        i_sb_addr,
   input  logic                     i_flush,
   output logic [DATA_W-1:0]        o_rdata_a,
   output logic [DATA_W-1:0]        o_rdata_b,
   output logic                     o_rvalid,
   output logic                     o_hazard,
   output logic [(2**ADDR_W)-1:0]   o_pending
);

   localparam int unsigned NUM_REGS = 2**ADDR_W;

   logic [DATA_W-1:0]   mem [NUM_REGS];
   logic [NUM_REGS-1:0] pending;
   logic [NUM_REGS-1:0] pending_nxt;

   logic                wr_en;
   logic                zero_a, zero_b;
   logic                fwd_a, fwd_b;
   logic                busy_a, busy_b;
   logic                accept;
   logic [DATA_W-1:0]   rval_a, rval_b;

   // Writes to the hard-wired zero register are dropped.
   assign wr_en  = i_we && !(ZERO_REG && (i_waddr == '0));

   assign zero_a = ZERO_REG && (i_raddr_a == '0);
   assign zero_b = ZERO_REG && (i_raddr_b == '0);
   assign fwd_a  = BYPASS && i_we && (i_waddr == i_raddr_a);
   assign fwd_b  = BYPASS && i_we && (i_waddr == i_raddr_b);

   // A pending source is released early when its write-back is being forwarded this cycle.
   assign busy_a   = pending[i_raddr_a] && !fwd_a && !zero_a;
   assign busy_b   = pending[i_raddr_b] && !fwd_b && !zero_b;
   assign o_hazard = i_re && (busy_a || busy_b);
   assign accept   = i_re && !o_hazard;

   // NOTE: every variable written in a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      rval_a = mem[i_raddr_a];
      if (zero_a)
         rval_a = '0;
      else if (fwd_a)
         rval_a = i_wdata;
   end

   always_comb begin
      rval_b = mem[i_raddr_b];
      if (zero_b)
         rval_b = '0;
      else if (fwd_b)
         rval_b = i_wdata;
   end

   // Flush beats reservation, reservation beats the write-back clear to the same entry.
   always_comb begin
      pending_nxt = pending;
      if (i_flush) begin
         pending_nxt = '0;
      end else begin
         if (i_we)
            pending_nxt[i_waddr] = 1'b0;
         if (i_sb_set && !(ZERO_REG && (i_sb_addr == '0)))
            pending_nxt[i_sb_addr] = 1'b1;
      end
      if (ZERO_REG)
         pending_nxt[0] = 1'b0;
   end

   // NOTE: the register array is cleared by reset because a read of an unwritten register must return zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++)
            mem[i] <= '0;
      end else if (wr_en) begin
         // NOTE: state is updated with non-blocking assignments so every reader in this edge sees the pre-edge value.
         mem[i_waddr] <= i_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pending <= '0;
      else
         pending <= pending_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_rdata_a <= '0;
         o_rdata_b <= '0;
         o_rvalid  <= 1'b0;
      end else begin
         o_rvalid <= accept;
         if (accept) begin
            o_rdata_a <= rval_a;
            o_rdata_b <= rval_b;
         end
      end
   end

   assign o_pending = pending;

endmodule

// File: tb/tb_data_regfile_sb.sv
// Directed bench for data_regfile_sb: default build, a ZERO_REG=0/BYPASS=0 build
// sharing the same stimulus, and a 16x32 build for a full write/read sweep.
module tb_data_regfile_sb;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // shared stimulus for the two 8x16 builds
   logic        we, re, sb_set, flush;
   logic [2:0]  waddr, raddr_a, raddr_b, sb_addr;
   logic [15:0] wdata;

   logic [15:0] rdata_a_d, rdata_b_d, rdata_a_n, rdata_b_n;
   logic        rvalid_d, hazard_d, rvalid_n, hazard_n;
   logic [7:0]  pending_d, pending_n;

   // 16x32 build
   logic        w_we, w_re;
   logic [3:0]  w_waddr, w_raddr_a, w_raddr_b;
   logic [31:0] w_wdata, w_rdata_a, w_rdata_b;
   logic        w_rvalid, w_hazard;
   logic [15:0] w_pending;

   int n_vec = 0;
   int n_err = 0;

   data_regfile_sb dut_d (
      .clk(clk), .rst_n(rst_n), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
      .i_re(re), .i_raddr_a(raddr_a), .i_raddr_b(raddr_b), .i_sb_set(sb_set),
      .i_sb_addr(sb_addr), .i_flush(flush), .o_rdata_a(rdata_a_d), .o_rdata_b(rdata_b_d),
      .o_rvalid(rvalid_d), .o_hazard(hazard_d), .o_pending(pending_d)
   );

   data_regfile_sb #(.ZERO_REG(1'b0), .BYPASS(1'b0)) dut_n (
      .clk(clk), .rst_n(rst_n), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
      .i_re(re), .i_raddr_a(raddr_a), .i_raddr_b(raddr_b), .i_sb_set(sb_set),
      .i_sb_addr(sb_addr), .i_flush(flush), .o_rdata_a(rdata_a_n), .o_rdata_b(rdata_b_n),
      .o_rvalid(rvalid_n), .o_hazard(hazard_n), .o_pending(pending_n)
   );

   data_regfile_sb #(.DATA_W(32), .ADDR_W(4)) dut_w (
      .clk(clk), .rst_n(rst_n), .i_we(w_we), .i_waddr(w_waddr), .i_wdata(w_wdata),
      .i_re(w_re), .i_raddr_a(w_raddr_a), .i_raddr_b(w_raddr_b), .i_sb_set(1'b0),
      .i_sb_addr(4'd0), .i_flush(1'b0), .o_rdata_a(w_rdata_a), .o_rdata_b(w_rdata_b),
      .o_rvalid(w_rvalid), .o_hazard(w_hazard), .o_pending(w_pending)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 0; re = 0; sb_set = 0; flush = 0;
      waddr = 0; raddr_a = 0; raddr_b = 0; sb_addr = 0; wdata = 0;
   endtask

   initial begin
      idle();
      w_we = 0; w_re = 0; w_waddr = 0; w_raddr_a = 0; w_raddr_b = 0; w_wdata = 0;
      rst_n = 0;
      step(); step();
      check("rst rdata_a", {16'h0, rdata_a_d}, 32'h0);
      check("rst rdata_b", {16'h0, rdata_b_d}, 32'h0);
      check("rst rvalid", {31'h0, rvalid_d}, 32'h0);
      check("rst pending", {24'h0, pending_d}, 32'h0);
      check("rst pending n", {24'h0, pending_n}, 32'h0);
      rst_n = 1;
      step();

      // write r3, read A=r3 B=r0
      we = 1; waddr = 3; wdata = 16'h1234;
      step();
      idle(); re = 1; raddr_a = 3; raddr_b = 0;
      step();
      check("rd r3 a", {16'h0, rdata_a_d}, 32'h1234);
      check("rd r0 b", {16'h0, rdata_b_d}, 32'h0);
      check("rd rvalid", {31'h0, rvalid_d}, 32'h1);
      check("rd r3 a n", {16'h0, rdata_a_n}, 32'h1234);
      re = 0;
      step();
      check("rvalid pulse", {31'h0, rvalid_d}, 32'h0);
      check("rdata hold", {16'h0, rdata_a_d}, 32'h1234);

      // reset in the middle of a read
      re = 1;
      step();
      check("pre-rst rvalid", {31'h0, rvalid_d}, 32'h1);
      re = 0;
      #2 rst_n = 0;
      #1;
      check("async rst rvalid", {31'h0, rvalid_d}, 32'h0);
      check("async rst rdata_a", {16'h0, rdata_a_d}, 32'h0);
      check("async rst rdata_a n", {16'h0, rdata_a_n}, 32'h0);
      #1 rst_n = 1;
      step();

      // zero register
      we = 1; waddr = 0; wdata = 16'hFFFF;
      step();
      idle(); re = 1; raddr_a = 0; raddr_b = 0;
      step();
      check("zero a", {16'h0, rdata_a_d}, 32'h0);
      check("zero b", {16'h0, rdata_b_d}, 32'h0);
      check("nozero a", {16'h0, rdata_a_n}, 32'hFFFF);
      check("nozero b", {16'h0, rdata_b_n}, 32'hFFFF);
      idle(); sb_set = 1; sb_addr = 0;
      step();
      check("zero pend", {24'h0, pending_d}, 32'h0);
      check("nozero pend", {24'h0, pending_n}, 32'h01);
      idle(); flush = 1;
      step();
      check("flush pend n", {24'h0, pending_n}, 32'h0);

      // bypass: write r5 while reading it
      idle(); we = 1; waddr = 5; wdata = 16'hBEEF; re = 1; raddr_a = 5; raddr_b = 3;
      step();
      check("bypass a", {16'h0, rdata_a_d}, 32'hBEEF);
      check("nobypass a", {16'h0, rdata_a_n}, 32'h0);
      check("bypass b r3", {16'h0, rdata_b_d}, 32'h0);
      idle(); re = 1; raddr_a = 5;
      step();
      check("r5 after a", {16'h0, rdata_a_d}, 32'hBEEF);
      check("r5 after a n", {16'h0, rdata_a_n}, 32'hBEEF);

      // scoreboard hazard on r2
      idle(); sb_set = 1; sb_addr = 2;
      step();
      check("resv pend", {24'h0, pending_d}, 32'h04);
      check("resv pend n", {24'h0, pending_n}, 32'h04);
      idle(); re = 1; raddr_a = 2; raddr_b = 5;
      #1;
      check("hazard", {31'h0, hazard_d}, 32'h1);
      check("hazard n", {31'h0, hazard_n}, 32'h1);
      step();
      check("haz no rvalid", {31'h0, rvalid_d}, 32'h0);
      check("haz hold a", {16'h0, rdata_a_d}, 32'hBEEF);
      we = 1; waddr = 2; wdata = 16'h0042;
      #1;
      check("wb haz drop", {31'h0, hazard_d}, 32'h0);
      check("wb haz stay n", {31'h0, hazard_n}, 32'h1);
      step();
      check("wb fwd a", {16'h0, rdata_a_d}, 32'h0042);
      check("wb fwd rvalid", {31'h0, rvalid_d}, 32'h1);
      check("wb rvalid n", {31'h0, rvalid_n}, 32'h0);
      we = 0;
      #1;
      check("haz drop n", {31'h0, hazard_n}, 32'h0);
      step();
      check("late a n", {16'h0, rdata_a_n}, 32'h0042);
      check("late rvalid n", {31'h0, rvalid_n}, 32'h1);

      // set/clear collision on r4: reservation wins, data is written
      idle(); sb_set = 1; sb_addr = 4; we = 1; waddr = 4; wdata = 16'h0007;
      step();
      check("coll pend", {24'h0, pending_d}, 32'h10);
      check("coll pend n", {24'h0, pending_n}, 32'h10);
      idle(); re = 1; raddr_a = 4; raddr_b = 2;
      #1;
      check("coll hazard", {31'h0, hazard_d}, 32'h1);
      idle(); flush = 1;
      step();
      check("flush clr", {24'h0, pending_d}, 32'h0);
      idle(); re = 1; raddr_a = 4; raddr_b = 2;
      step();
      check("coll mem a", {16'h0, rdata_a_d}, 32'h0007);
      check("coll mem b", {16'h0, rdata_b_d}, 32'h0042);
      check("coll mem a n", {16'h0, rdata_a_n}, 32'h0007);

      // flush with set and write in the same cycle
      idle(); flush = 1; sb_set = 1; sb_addr = 6; we = 1; waddr = 6; wdata = 16'h0009;
      step();
      check("flush+set pend", {24'h0, pending_d}, 32'h0);
      check("flush+set pend n", {24'h0, pending_n}, 32'h0);
      check("flush keeps rdata", {16'h0, rdata_a_d}, 32'h0007);

      // read and reserve the same source in one cycle
      idle(); re = 1; raddr_a = 6; raddr_b = 6; sb_set = 1; sb_addr = 6;
      #1;
      check("rd+resv hazard", {31'h0, hazard_d}, 32'h0);
      step();
      check("rd+resv a", {16'h0, rdata_a_d}, 32'h0009);
      check("rd+resv b", {16'h0, rdata_b_d}, 32'h0009);
      check("rd+resv pend", {24'h0, pending_d}, 32'h40);
      idle();
      step();

      // 16x32 sweep
      for (int i = 0; i < 16; i++) begin
         w_we = 1; w_waddr = 4'(i); w_wdata = 32'(i) * 32'h01010101;
         step();
      end
      w_we = 0;
      for (int i = 0; i < 8; i++) begin
         w_re = 1; w_raddr_a = 4'(i); w_raddr_b = 4'(15 - i);
         #1;
         check($sformatf("sweep haz %0d", i), {31'h0, w_hazard}, 32'h0);
         step();
         check($sformatf("sweep a %0d", i), w_rdata_a, 32'(i) * 32'h01010101);
         check($sformatf("sweep b %0d", 15 - i), w_rdata_b, 32'(15 - i) * 32'h01010101);
      end
      w_re = 0;
      step();
      check("sweep pend", {16'h0, w_pending}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
